// File: rtl/irq_priority_pkg.sv
// Shared types and constants for the interrupt priority controller.
// Optional round-robin channel selection is enabled with `define IRQ_RR_EN.
package irq_priority_pkg;

  // Upper bounds of the supported configuration space.
  localparam int unsigned MAX_CH  = 32;
  localparam int unsigned MAX_BUS = 4;

  typedef enum logic [0:0] {IDLE, GRANT} irq_state_e;

  // Index width for a set of n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) w = $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Circular first-set search over one bus's eligible channels.
// With IRQ_RR_EN undefined the parent ties start_i to 0, giving fixed priority.
module irq_prio_pick
  import irq_priority_pkg::*;
#(
  parameter int unsigned NUM_CH = 9,
  localparam int unsigned CH_W  = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] vec_i,
  input  logic [CH_W-1:0]   start_i,
  output logic              found_o,
  output logic [CH_W-1:0]   idx_o
);

  // Scan from start_i upward, wrapping at NUM_CH; first eligible bit wins.
  always_comb begin
    logic              hit;
    int unsigned       k;
    logic [CH_W-1:0]   kk;
    hit   = 1'b0;
    idx_o = '0;
    k     = 0;
    kk    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      k = 32'(start_i) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      kk = CH_W'(k);
      if (!hit && vec_i[kk]) begin
        hit   = 1'b1;
        idx_o = kk;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Registered interrupt priority controller: pending latch, eligibility qualification,
// bus-then-channel arbitration and a valid/ack grant handshake that is never retracted.
// `define IRQ_RR_EN selects per-bus round-robin channel order; default is fixed priority.
module irq_priority_ctrl
  import irq_priority_pkg::*;
#(
  parameter int unsigned NUM_CH  = 9,
  parameter int unsigned NUM_BUS = 3,
  localparam int unsigned CH_W   = idx_width(NUM_CH),
  localparam int unsigned BUS_W  = idx_width(NUM_BUS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_BUS*NUM_CH-1:0]  req_i,
  input  logic [NUM_CH-1:0]          ch_en_i,
  input  logic [NUM_BUS*NUM_CH-1:0]  mask_i,
  input  logic                       irq_ack_i,
  output logic                       irq_valid_o,
  output logic [BUS_W-1:0]           irq_bus_o,
  output logic [CH_W-1:0]            irq_ch_o,
  output logic [NUM_BUS-1:0]         bus_active_o,
  output logic [NUM_BUS*NUM_CH-1:0]  pending_o
);

  localparam int unsigned NUM_IRQ = NUM_BUS * NUM_CH;

  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_ch
    $error("NUM_CH out of range");
  end
  if (NUM_BUS < 1 || NUM_BUS > MAX_BUS) begin : g_bad_bus
    $error("NUM_BUS out of range");
  end

  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] clr;
  irq_state_e         state_q;
  logic [BUS_W-1:0]   bus_q;
  logic [CH_W-1:0]    ch_q;
  logic               ack_fire;
  logic [31:0]        grant_idx;
  logic [NUM_BUS-1:0] found;
  logic [NUM_BUS-1:0] first;
  logic               any_elig;
  logic [BUS_W-1:0]   win_bus;
  logic [CH_W-1:0]    win_ch;

  assign elig      = pending_q & ~mask_i & {NUM_BUS{ch_en_i}};
  assign ack_fire  = (state_q == GRANT) & irq_ack_i;
  assign grant_idx = 32'(bus_q) * NUM_CH + 32'(ch_q);
  // Only the granted bit is cleared, and only on an accepted handshake.
  assign clr       = ack_fire ? (NUM_IRQ'(1) << grant_idx) : '0;

  // Latch level requests; a request still high during its ack stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= req_i | (pending_q & ~clr);
  end

  // Lowest-numbered bus with an eligible request wins.
  assign first    = found & (~found + NUM_BUS'(1));
  assign any_elig = |found;

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_bus
    logic              hit;
    logic [CH_W-1:0]   idx;
    logic [CH_W-1:0]   start;
    logic [BUS_W-1:0]  acc_bus;
    logic [CH_W-1:0]   acc_ch;

    assign bus_active_o[b] = |elig[b*NUM_CH +: NUM_CH];

`ifdef IRQ_RR_EN
    logic [CH_W-1:0] ptr_q;
    // Advance this bus's pointer past the channel whose grant was just accepted.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr_q <= '0;
      end else if (ack_fire && bus_q == BUS_W'(b)) begin
        ptr_q <= (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
      end
    end
    assign start = ptr_q;
`else
    assign start = '0;
`endif

    irq_prio_pick #(
      .NUM_CH (NUM_CH)
    ) u_pick (
      .vec_i   (elig[b*NUM_CH +: NUM_CH]),
      .start_i (start),
      .found_o (hit),
      .idx_o   (idx)
    );

    assign found[b] = hit;

    // OR-chain of one-hot-selected terms forms the bus-priority mux.
    if (b == 0) begin : g_first
      assign acc_bus = first[b] ? BUS_W'(b) : '0;
      assign acc_ch  = first[b] ? idx : '0;
    end else begin : g_rest
      assign acc_bus = g_bus[b-1].acc_bus | (first[b] ? BUS_W'(b) : '0);
      assign acc_ch  = g_bus[b-1].acc_ch | (first[b] ? idx : '0);
    end
  end

  assign win_bus = g_bus[NUM_BUS-1].acc_bus;
  assign win_ch  = g_bus[NUM_BUS-1].acc_ch;

  // Grant FSM: capture a winner in IDLE, hold it frozen in GRANT until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bus_q   <= '0;
      ch_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_elig) begin
            bus_q   <= win_bus;
            ch_q    <= win_ch;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (irq_ack_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_valid_o = (state_q == GRANT);
  assign irq_bus_o   = bus_q;
  assign irq_ch_o    = ch_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench for irq_priority_ctrl (NUM_CH=9, NUM_BUS=3).
// Honours `define IRQ_RR_EN for the expected channel order.
module tb_irq_priority_ctrl;

  localparam int NCH  = 9;
  localparam int NBUS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [26:0] req = '0;
  logic [26:0] mask = '0;
  logic [8:0]  en = '1;
  logic        ack = 1'b0;
  logic        valid;
  logic [1:0]  bus;
  logic [3:0]  ch;
  logic [2:0]  active;
  logic [26:0] pend;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_priority_ctrl #(
    .NUM_CH  (NCH),
    .NUM_BUS (NBUS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .ch_en_i      (en),
    .mask_i       (mask),
    .irq_ack_i    (ack),
    .irq_valid_o  (valid),
    .irq_bus_o    (bus),
    .irq_ch_o     (ch),
    .bus_active_o (active),
    .pending_o    (pend)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a set of pending requests plus the currently held grant.
  bit [26:0] m_pend;
  bit        m_valid;
  int        m_bus, m_ch;
  int        m_ptr[NBUS];

  function automatic bit bit_of(input logic [26:0] v, input int i);
    return ((v >> i) & 27'd1) != 27'd0;
  endfunction

  function automatic bit m_elig(input int b, input int c);
    return bit_of(m_pend, b*NCH + c) && !bit_of(mask, b*NCH + c) && bit_of({18'd0, en}, c);
  endfunction

  function automatic bit m_find(output int wb, output int wc);
    wb = 0;
    wc = 0;
    for (int b = 0; b < NBUS; b++)
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr[b] + k) % NCH;
        if (m_elig(b, c)) begin
          wb = b;
          wc = c;
          return 1'b1;
        end
      end
    return 1'b0;
  endfunction

  function automatic logic [2:0] m_active();
    logic [2:0] a;
    a = '0;
    for (int b = 0; b < NBUS; b++)
      for (int c = 0; c < NCH; c++)
        if (m_elig(b, c)) a = a | (3'd1 << b);
    return a;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend  <= '0;
      m_valid <= 1'b0;
      m_bus   <= 0;
      m_ch    <= 0;
      for (int b = 0; b < NBUS; b++) m_ptr[b] <= 0;
    end else begin
      int wb, wc;
      bit [26:0] clrv;
      clrv = (m_valid && ack) ? (27'd1 << (m_bus*NCH + m_ch)) : '0;
      m_pend <= req | (m_pend & ~clrv);
      if (!m_valid) begin
        if (m_find(wb, wc)) begin
          m_valid <= 1'b1;
          m_bus   <= wb;
          m_ch    <= wc;
        end
      end else if (ack) begin
        m_valid <= 1'b0;
`ifdef IRQ_RR_EN
        m_ptr[m_bus] <= (m_ch + 1) % NCH;
`endif
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("valid", valid, m_valid);
    chk("pending", pend, m_pend);
    chk("bus_active", active, m_active());
    if (m_valid) begin
      chk("bus", bus, m_bus);
      chk("ch", ch, m_ch);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    for (int i = 0; i < max; i++) begin
      if (valid) break;
      tick();
    end
    ok = valid;
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit ok;
    int exp5[4];
`ifdef IRQ_RR_EN
    exp5 = '{1, 2, 1, 2};
`else
    exp5 = '{1, 1, 1, 1};
`endif

    // 1: outputs stay 0 in reset regardless of inputs
    for (int i = 0; i < 5; i++) begin
      req  = 27'($urandom);
      mask = 27'($urandom);
      en   = 9'($urandom);
      ack  = 1'($urandom);
      @(negedge clk);
      #1;
      chk("t1_rst_valid", valid, 0);
      chk("t1_rst_pend", pend, 0);
      chk("t1_rst_active", active, 0);
      chk("t1_rst_bus", bus, 0);
      chk("t1_rst_ch", ch, 0);
    end
    req = '0; mask = '0; en = '1; ack = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t1_idle_valid", valid, 0);

    // 2: simultaneous bus0/ch7 and bus1/ch4, bus 0 first
    req = (27'd1 << 7) | (27'd1 << (NCH + 4));
    tick();
    req = '0;
    tick();
    chk("t2_g1_valid", valid, 1);
    chk("t2_g1_bus", bus, 0);
    chk("t2_g1_ch", ch, 7);
    ack = 1'b1;
    tick();
    chk("t2_bubble", valid, 0);
    tick();
    chk("t2_g2_valid", valid, 1);
    chk("t2_g2_bus", bus, 1);
    chk("t2_g2_ch", ch, 4);
    tick();
    ack = 1'b0;
    chk("t2_done", valid, 0);

    // 3: channel enable gates eligibility combinationally
    en  = 9'h1F7;
    req = 27'd1 << 3;
    tick();
    req = '0;
    tick();
    tick();
    chk("t3_dis_active", active, 0);
    chk("t3_dis_valid", valid, 0);
    en = '1;
    #1;
    chk("t3_en_active", active, 3'b001);
    chk("t3_en_valid", valid, 0);
    tick();
    chk("t3_valid", valid, 1);
    chk("t3_bus", bus, 0);
    chk("t3_ch", ch, 3);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // 4: grant held without ack is not preempted by a higher-priority request
    req = 27'd1 << (2*NCH + 5);
    tick();
    req = '0;
    tick();
    chk("t4_valid", valid, 1);
    req = 27'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      req = '0;
      chk("t4_hold_bus", bus, 2);
      chk("t4_hold_ch", ch, 5);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t4_bubble", valid, 0);
    tick();
    chk("t4_next_valid", valid, 1);
    chk("t4_next_bus", bus, 0);
    chk("t4_next_ch", ch, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // 5: channel order with two held requests on bus 0
    req = (27'd1 << 1) | (27'd1 << 2);
    for (int g = 0; g < 4; g++) begin
      wait_valid(8, ok);
      chk("t5_wait", ok, 1);
      chk("t5_bus", bus, 0);
      chk("t5_seq", ch, exp5[g]);
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    req = '0;
    ack = 1'b1;
    repeat (6) tick();
    ack = 1'b0;
    tick();
    chk("t5_drained_pend", pend, 0);
    chk("t5_drained_valid", valid, 0);

    // 6: asynchronous reset mid-grant, then regrant of the held request
    req = 27'd1 << (NCH + 1);
    tick();
    tick();
    chk("t6_valid", valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_pend", pend, 0);
    chk("t6_rst_active", active, 0);
    chk("t6_rst_bus", bus, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_relatch", pend, 27'd1 << (NCH + 1));
    chk("t6_not_yet", valid, 0);
    tick();
    chk("t6_regrant_valid", valid, 1);
    chk("t6_regrant_bus", bus, 1);
    chk("t6_regrant_ch", ch, 1);
    req = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("t6_end_valid", valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
